// File: rtl/threshold_unit_mc.sv
// threshold_unit_mc
// Time-multiplexed multi-channel spike generator. Each accepted
// (channel, potential) sample is compared against that channel's effective
// threshold. The unit keeps a refractory counter for each channel and
// registers one result per sample behind a valid/ready output stage.
//
// Build option: define THRESHOLD_ADAPT_EN to add a per-channel adaptive
// threshold offset. When the macro is undefined, the offset registers are
// not generated. The ports are identical in both builds.
module threshold_unit_mc #(
  parameter int DATA_WIDTH   = 16,
  parameter int NUM_CHANNELS = 8,
  parameter int CH_W         = 3,
  parameter int REFRAC_WIDTH = 4,
  parameter int THR_INC      = 4,
  parameter int THR_MAX_OFF  = 64
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic signed [DATA_WIDTH-1:0]  cfg_threshold,
  input  logic [REFRAC_WIDTH-1:0]       cfg_refrac,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CH_W-1:0]               in_chan,
  input  logic signed [DATA_WIDTH-1:0]  in_potential,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CH_W-1:0]               out_chan,
  output logic                          out_spike
);

  // Output register stage
  logic                    r_out_valid;
  logic [CH_W-1:0]         r_out_chan;
  logic                    r_out_spike;

  // Handshake and per-sample decision
  logic                    w_accept;
  logic                    w_chan_ok;
  logic                    w_spike;
  logic [REFRAC_WIDTH-1:0] w_rc_sel;
  logic [REFRAC_WIDTH-1:0] w_rc_all [NUM_CHANNELS];

  // Compare operands, one bit wider than the data so nothing can wrap
  logic signed [DATA_WIDTH:0] w_pot_ext;
  logic signed [DATA_WIDTH:0] w_thr_base;
  logic signed [DATA_WIDTH:0] w_thr_eff;

  // There is a single output register and no skid buffer. A new sample is
  // accepted only when that register is empty or is being drained.
  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  // Out-of-range channel indices are still accepted. They never fire and
  // never change any channel state.
  assign w_chan_ok = ({1'b0, in_chan} < (CH_W+1)'(NUM_CHANNELS));

  assign w_pot_ext  = {in_potential[DATA_WIDTH-1], in_potential};
  assign w_thr_base = {cfg_threshold[DATA_WIDTH-1], cfg_threshold};

  // Mux the addressed channel's refractory count; 0 for an invalid channel
  always_comb begin
    w_rc_sel = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (in_chan == CH_W'(c)) begin
        w_rc_sel = w_rc_all[c];
      end
    end
  end

`ifdef THRESHOLD_ADAPT_EN
  localparam int OFF_W = $clog2(THR_MAX_OFF + 1);

  logic [OFF_W-1:0] w_off_sel;
  logic [OFF_W-1:0] w_off_all [NUM_CHANNELS];

  // Mux the addressed channel's adaptive offset
  always_comb begin
    w_off_sel = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (in_chan == CH_W'(c)) begin
        w_off_sel = w_off_all[c];
      end
    end
  end

  // The offset is unsigned. It is zero-extended and added to the base threshold.
  assign w_thr_eff = w_thr_base + $signed({{(DATA_WIDTH+1-OFF_W){1'b0}}, w_off_sel});
`else
  // These parameters only size the adaptive logic, which is absent in this build
  logic w_unused_adapt_params;
  assign w_unused_adapt_params = (THR_INC != 0) ^ (THR_MAX_OFF != 0);

  assign w_thr_eff = w_thr_base;
`endif

  // A refractory channel never fires; otherwise signed compare, equality fires
  assign w_spike = w_chan_ok && (w_rc_sel == '0) && (w_pot_ext >= w_thr_eff);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [REFRAC_WIDTH-1:0] r_rc;
      logic                    w_hit;

      assign w_hit = w_accept && w_chan_ok && (in_chan == CH_W'(gi));

      // Refractory counter: count down once per accepted sample, reload on a spike
      always_ff @(posedge clk) begin
        if (rst) begin
          r_rc <= '0;
        end else if (w_hit) begin
          if (r_rc != '0) begin
            r_rc <= r_rc - REFRAC_WIDTH'(1);
          end else if (w_spike) begin
            r_rc <= cfg_refrac;
          end
        end
      end

      assign w_rc_all[gi] = r_rc;

`ifdef THRESHOLD_ADAPT_EN
      logic [OFF_W-1:0] r_off;

      // Adaptive offset: saturating bump on a spike, decay by one otherwise
      always_ff @(posedge clk) begin
        if (rst) begin
          r_off <= '0;
        end else if (w_hit) begin
          if (w_spike) begin
            if (int'(r_off) + THR_INC >= THR_MAX_OFF) begin
              r_off <= OFF_W'(THR_MAX_OFF);
            end else begin
              r_off <= r_off + OFF_W'(THR_INC);
            end
          end else if (r_off != '0) begin
            r_off <= r_off - OFF_W'(1);
          end
        end
      end

      assign w_off_all[gi] = r_off;
`endif
    end
  endgenerate

  // Output register: load on accept, clear on drain, hold while stalled
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_chan  <= '0;
      r_out_spike <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_chan  <= in_chan;
      r_out_spike <= w_spike;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_chan  = r_out_chan;
  assign out_spike = r_out_spike;

endmodule

// File: tb/tb_threshold_unit_mc.sv
// Testbench for threshold_unit_mc, set up with NUM_CHANNELS=8 and CH_W=4 so
// that out-of-range channels can be exercised. A behavioural model predicts
// each result when a sample is accepted and pushes it to a scoreboard. A
// monitor pops and compares an entry on every output transfer.
module tb_threshold_unit_mc;

  localparam int DW  = 16;
  localparam int NCH = 8;
  localparam int CHW = 4;
  localparam int RW  = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic signed [DW-1:0]  cfg_threshold;
  logic [RW-1:0]         cfg_refrac;
  logic                  in_valid;
  logic                  in_ready;
  logic [CHW-1:0]        in_chan;
  logic signed [DW-1:0]  in_potential;
  logic                  out_valid;
  logic                  out_ready;
  logic [CHW-1:0]        out_chan;
  logic                  out_spike;

  typedef struct {
    int chan;
    int spike;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks  = 0;
  int   n_errors  = 0;
  int   n_sent    = 0;
  int   n_dropped = 0;
  int   n_xfer    = 0;
  bit   rand_rdy  = 1'b0;

  // Model state
  int m_rc  [NCH];
  int m_off [NCH];

  threshold_unit_mc #(
    .DATA_WIDTH  (DW),
    .NUM_CHANNELS(NCH),
    .CH_W        (CHW),
    .REFRAC_WIDTH(RW),
    .THR_INC     (4),
    .THR_MAX_OFF (64)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_threshold(cfg_threshold),
    .cfg_refrac   (cfg_refrac),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_chan      (in_chan),
    .in_potential (in_potential),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_chan     (out_chan),
    .out_spike    (out_spike)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_rc[c]  = 0;
      m_off[c] = 0;
    end
  endfunction

  // Predict one accepted sample and advance the model state
  function automatic int model(input int c, input int p);
    int thr;
    int s;
    if (c >= NCH) return 0;
    if (m_rc[c] != 0) begin
      m_rc[c] = m_rc[c] - 1;
`ifdef THRESHOLD_ADAPT_EN
      if (m_off[c] > 0) m_off[c] = m_off[c] - 1;
`endif
      return 0;
    end
    thr = int'(cfg_threshold) + m_off[c];
    s = (p >= thr) ? 1 : 0;
    if (s == 1) begin
      m_rc[c] = int'(cfg_refrac);
`ifdef THRESHOLD_ADAPT_EN
      m_off[c] = (m_off[c] + 4 > 64) ? 64 : m_off[c] + 4;
`endif
    end else begin
`ifdef THRESHOLD_ADAPT_EN
      if (m_off[c] > 0) m_off[c] = m_off[c] - 1;
`endif
    end
    return s;
  endfunction

  // Present a sample and wait (bounded) for it to be accepted
  task automatic send(input int c, input int p);
    int   waits;
    exp_t e;
    in_valid     = 1'b1;
    in_chan      = CHW'(c);
    in_potential = DW'(p);
    waits = 0;
    @(negedge clk);
    while (!in_ready && waits < 50) begin
      @(negedge clk);
      waits++;
    end
    if (!in_ready) begin
      check("send_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    e.chan  = c;
    e.spike = model(c, p);
    sb_q.push_back(e);
    n_sent++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("lat_valid", out_valid, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every transferred result against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_unexpected", 1, 0);
      end else begin
        e = sb_q.pop_front();
        $display("xfer ch=%0d spike=%0d (exp ch=%0d spike=%0d)", out_chan, out_spike, e.chan, e.spike);
        check("out_chan", out_chan, e.chan);
        check("out_spike", out_spike, e.spike);
        n_xfer++;
      end
    end
  end

  // Random back-pressure during the random phase
  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    int waits;
    rst = 1'b1;
    cfg_threshold = 16'sd100;
    cfg_refrac = '0;
    in_valid = 1'b0;
    in_chan = '0;
    in_potential = '0;
    out_ready = 1'b1;
    model_reset();
    idle(3);
    rst = 1'b0;

    // Reset state
    check("rst_out_valid", out_valid, 0);
    check("rst_out_spike", out_spike, 0);
    check("rst_out_chan", out_chan, 0);
    check("rst_in_ready", in_ready, 1);

    // Equality fires
    send(2, 100);
    idle(1);

    // Refractory period on ch0, interleaved with ch1
    cfg_refrac = 4'd2;
    send(0, 200);
    send(1, 50);
    send(0, 200);
    send(1, 200);
    send(0, 200);
    send(1, 50);
    send(0, 200);
    send(1, 50);
    idle(2);

    // Stall: the pending result holds while out_ready is low
    out_ready = 1'b0;
    send(3, 150);
    in_valid = 1'b1;
    in_chan = CHW'(6);
    in_potential = 16'sd10;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid", out_valid, 1);
      check("stall_out_chan", out_chan, sb_q[0].chan);
      check("stall_out_spike", out_spike, sb_q[0].spike);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(6, 10);
    idle(2);

    // Extreme signed values
    cfg_refrac = 4'd0;
    cfg_threshold = 16'sh7FFF;
    send(7, -32768);
    idle(1);
    cfg_threshold = -16'sd32768;
    send(7, 32767);
    idle(1);

    // Invalid channel
    cfg_threshold = 16'sd100;
    cfg_refrac = 4'd2;
    send(9, 500);
    send(1, 500);
    send(9, 500);
    send(1, 500);
    idle(2);

`ifdef THRESHOLD_ADAPT_EN
    // Adaptive threshold on ch5
    cfg_refrac = 4'd0;
    send(5, 103);
    send(5, 103);
    for (int i = 0; i < 4; i++) send(5, 0);
    send(5, 103);
    idle(2);
`endif

    // Reset while a result is pending
    cfg_refrac = 4'd3;
    send(4, 200);
    idle(1);
    out_ready = 1'b0;
    send(4, 200);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    check("rst_mid_out_valid", out_valid, 0);
    n_dropped += sb_q.size();
    sb_q.delete();
    model_reset();
    out_ready = 1'b1;
    send(4, 200);
    idle(2);

    // Random traffic with random back-pressure
    cfg_threshold = 16'sd0;
    cfg_refrac = RW'($urandom_range(0, 3));
    rand_rdy = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if (i % 50 == 49) cfg_refrac = RW'($urandom_range(0, 3));
      send(($urandom_range(0, 15) == 0) ? 8 + $urandom_range(0, 7) : $urandom_range(0, NCH - 1),
           $urandom_range(0, 200) - 100);
    end
    rand_rdy = 1'b0;
    idle(1);
    out_ready = 1'b1;

    // Drain
    waits = 0;
    while (sb_q.size() != 0 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    idle(1);
    check("drain_empty", sb_q.size(), 0);
    check("xfer_count", n_xfer, n_sent - n_dropped);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
